// File: rtl/seg7_pkg.sv
// Shared constants, scan state type and nibble-to-segment lookup for the 7-segment driver.
package seg7_pkg;

    // Active-low segment patterns: bit7 = DP (off here), bits6:0 = g..a
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_A    = 8'h88;
    localparam logic [7:0] SEG_B    = 8'h83;
    localparam logic [7:0] SEG_C    = 8'hC6;
    localparam logic [7:0] SEG_D    = 8'hA1;
    localparam logic [7:0] SEG_E    = 8'h86;
    localparam logic [7:0] SEG_F    = 8'h8E;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    // Codes above 9 fall back to a dash unless hex display is enabled
    function automatic logic [7:0] seg7_code(input logic [3:0] nibble, input logic hex_mode);
        logic [7:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        if (!hex_mode && (nibble > 4'd9)) begin
            code = SEG_DASH;
        end
        return code;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational encoder for one digit: segment pattern, leading-zero blank and decimal point.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] leds
);

    // Blanking only clears the digit segments; the DP stays under caller control
    always_comb begin
        leds = seg7_code(nibble, hex_mode);
        if (blank) begin
            leds[6:0] = 7'h7F;
        end
        leds[7] = ~dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NDIGITS 7-segment scan driver with blanking gaps, double-buffered display
// value behind a load/ack handshake, and leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NDIGITS   = 4,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter bit          HEX_MODE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4*NDIGITS-1:0] digits_in,
    input  logic [NDIGITS-1:0]   dp_in,
    input  logic                 load,
    input  logic                 lzb_en,
    output logic                 load_ack,
    output logic                 frame_done,
    output logic [7:0]           leds,
    output logic [NDIGITS-1:0]   digit_sel_n
);

    localparam int unsigned ShowCyc = SCAN_DIV - BLANK_CYC;
    localparam int unsigned CntW    = $clog2(SCAN_DIV);
    localparam int unsigned IdxW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    scan_state_t            state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [4*NDIGITS-1:0]   stage_digits_q, stage_digits_d;
    logic [NDIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic                   stage_lzb_q, stage_lzb_d;
    logic                   pending_q, pending_d;
    logic [4*NDIGITS-1:0]   disp_digits_q, disp_digits_d;
    logic [NDIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                   disp_lzb_q, disp_lzb_d;
    logic [7:0]             leds_q, leds_d;
    logic [NDIGITS-1:0]     sel_q, sel_d;
    logic                   load_ack_q, load_ack_d;
    logic                   frame_done_q, frame_done_d;

    logic                   wrap;
    logic [NDIGITS-1:0]     lzb_mask;
    logic                   zero_run;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [7:0]             cur_leds;

    // Leading-zero mask: a digit blanks while it and everything above it are zero
    always_comb begin
        zero_run = 1'b1;
        lzb_mask = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (disp_digits_q[4*i +: 4] == 4'd0);
            lzb_mask[i] = disp_lzb_q & zero_run & (i != 0);
        end
    end

    // Select the nibble, DP and blank flag of the digit currently being scanned
    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (IdxW'(i) == idx_q) begin
                cur_nib   = disp_digits_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = lzb_mask[i];
            end
        end
    end

    seg7_encode u_encode (
        .nibble   (cur_nib),
        .hex_mode (HEX_MODE),
        .blank    (cur_blank),
        .dp       (cur_dp),
        .leds     (cur_leds)
    );

    // Scan FSM, handshake and registered-output next state
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q + CntW'(1);
        wrap           = 1'b0;
        stage_digits_d = stage_digits_q;
        stage_dp_d     = stage_dp_q;
        stage_lzb_d    = stage_lzb_q;
        pending_d      = pending_q;
        disp_digits_d  = disp_digits_q;
        disp_dp_d      = disp_dp_q;
        disp_lzb_d     = disp_lzb_q;
        leds_d         = SEG_OFF;
        sel_d          = '1;

        case (state_q)
            BLANK: begin
                if (cnt_q == CntW'(BLANK_CYC - 1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CntW'(ShowCyc - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IdxW'(NDIGITS - 1)) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
        endcase

        // The wrap consumes the old staging; a load on that same cycle stays pending
        if (wrap && pending_q) begin
            disp_digits_d = stage_digits_q;
            disp_dp_d     = stage_dp_q;
            disp_lzb_d    = stage_lzb_q;
            pending_d     = 1'b0;
        end
        if (load) begin
            stage_digits_d = digits_in;
            stage_dp_d     = dp_in;
            stage_lzb_d    = lzb_en;
            pending_d      = 1'b1;
        end

        load_ack_d   = wrap & pending_q;
        frame_done_d = wrap;

        // Entering or staying in SHOW never changes idx or the display value
        if (state_d == SHOW) begin
            leds_d       = cur_leds;
            sel_d[idx_q] = 1'b0;
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= BLANK;
            idx_q          <= '0;
            cnt_q          <= '0;
            stage_digits_q <= '0;
            stage_dp_q     <= '0;
            stage_lzb_q    <= 1'b0;
            pending_q      <= 1'b0;
            disp_digits_q  <= '0;
            disp_dp_q      <= '0;
            disp_lzb_q     <= 1'b0;
            leds_q         <= SEG_OFF;
            sel_q          <= '1;
            load_ack_q     <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            stage_digits_q <= stage_digits_d;
            stage_dp_q     <= stage_dp_d;
            stage_lzb_q    <= stage_lzb_d;
            pending_q      <= pending_d;
            disp_digits_q  <= disp_digits_d;
            disp_dp_q      <= disp_dp_d;
            disp_lzb_q     <= disp_lzb_d;
            leds_q         <= leds_d;
            sel_q          <= sel_d;
            load_ack_q     <= load_ack_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign leds        = leds_q;
    assign digit_sel_n = sel_q;
    assign load_ack    = load_ack_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: one hex-mode and one dash-mode driver share stimulus; each frame is
// walked cycle by cycle against hand-computed segment patterns.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lzb_en;

    logic        ack_h, fd_h, ack_d, fd_d;
    logic [7:0]  leds_h, leds_d;
    logic [3:0]  sel_h, sel_d;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver #(
        .NDIGITS   (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .HEX_MODE  (1'b1)
    ) dut_hex (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .lzb_en      (lzb_en),
        .load_ack    (ack_h),
        .frame_done  (fd_h),
        .leds        (leds_h),
        .digit_sel_n (sel_h)
    );

    seg7_scan_driver #(
        .NDIGITS   (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .HEX_MODE  (1'b0)
    ) dut_dash (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .lzb_en      (lzb_en),
        .load_ack    (ack_d),
        .frame_done  (fd_d),
        .leds        (leds_d),
        .digit_sel_n (sel_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next frame_done (sampled on the falling edge), bounded
    task automatic wait_fd();
        int n;
        n = 0;
        while (fd_h !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_timeout", {31'd0, fd_h}, 32'd1);
    endtask

    // Walk one 32-cycle frame starting on its frame_done cycle, optionally issuing loads
    task automatic walk_frame(input string name,
                              input logic [3:0][7:0] exp_h, input logic [3:0][7:0] exp_d,
                              input bit ack,
                              input int ld1_at, input logic [15:0] ld1_val,
                              input int ld2_at, input logic [15:0] ld2_val,
                              input logic [3:0] ld_dp, input logic ld_lzb);
        int d, off;
        logic [7:0] el_h, el_d;
        logic [3:0] es;
        for (int k = 0; k < 32; k++) begin
            d   = k / 8;
            off = k % 8;
            if (off < 2) begin
                el_h = 8'hFF;
                el_d = 8'hFF;
                es   = 4'hF;
            end else begin
                el_h = exp_h[d];
                el_d = exp_d[d];
                es   = ~(4'b0001 << d);
            end
            check($sformatf("%s k%0d leds_hex", name, k), {24'd0, leds_h}, {24'd0, el_h});
            check($sformatf("%s k%0d leds_dash", name, k), {24'd0, leds_d}, {24'd0, el_d});
            check($sformatf("%s k%0d sel", name, k), {28'd0, sel_h}, {28'd0, es});
            check($sformatf("%s k%0d frame_done", name, k), {31'd0, fd_h}, {31'd0, k == 0});
            check($sformatf("%s k%0d load_ack", name, k), {31'd0, ack_h},
                  {31'd0, (k == 0) && ack});
            if (k == ld1_at || k == ld2_at) begin
                load      = 1'b1;
                digits_in = (k == ld1_at) ? ld1_val : ld2_val;
                dp_in     = ld_dp;
                lzb_en    = ld_lzb;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        load      = 1'b0;
        lzb_en    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst leds", {24'd0, leds_h}, 32'hFF);
        check("rst sel", {28'd0, sel_h}, 32'hF);
        check("rst load_ack", {31'd0, ack_h}, 32'd0);
        check("rst frame_done", {31'd0, fd_h}, 32'd0);

        reset_n   = 1'b1;
        load      = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'h0;
        lzb_en    = 1'b0;
        @(negedge clk);
        load = 1'b0;
        wait_fd();

        walk_frame("f1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 1'b1,
                   10, 16'hABCD, -1, 16'h0, 4'h0, 1'b0);
        walk_frame("fABCD", {8'h88, 8'h83, 8'hC6, 8'hA1}, {8'hBF, 8'hBF, 8'hBF, 8'hBF}, 1'b1,
                   5, 16'h0005, -1, 16'h0, 4'h0, 1'b1);
        walk_frame("f0005", {8'hFF, 8'hFF, 8'hFF, 8'h92}, {8'hFF, 8'hFF, 8'hFF, 8'h92}, 1'b1,
                   5, 16'h0000, -1, 16'h0, 4'h0, 1'b1);
        walk_frame("f0000", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 1'b1,
                   5, 16'h0100, -1, 16'h0, 4'h0, 1'b1);
        walk_frame("f0100", {8'hFF, 8'hF9, 8'hC0, 8'hC0}, {8'hFF, 8'hF9, 8'hC0, 8'hC0}, 1'b1,
                   5, 16'h0005, -1, 16'h0, 4'b0100, 1'b1);
        walk_frame("fdp", {8'hFF, 8'h7F, 8'hFF, 8'h92}, {8'hFF, 8'h7F, 8'hFF, 8'h92}, 1'b1,
                   3, 16'h1111, 20, 16'h2222, 4'h0, 1'b0);
        walk_frame("f2222", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 1'b1,
                   31, 16'h0987, -1, 16'h0, 4'h0, 1'b0);
        walk_frame("fhold", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 1'b0,
                   -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
        walk_frame("f0987", {8'hC0, 8'h90, 8'h80, 8'hF8}, {8'hC0, 8'h90, 8'h80, 8'hF8}, 1'b1,
                   -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

        // Mid-scan reset during SHOW of digit 2
        repeat (20) @(negedge clk);
        check("mid pre sel", {28'd0, sel_h}, 32'hB);
        check("mid pre leds", {24'd0, leds_h}, 32'h90);
        #2 reset_n = 1'b0;
        #1;
        check("mid rst leds", {24'd0, leds_h}, 32'hFF);
        check("mid rst sel", {28'd0, sel_h}, 32'hF);
        check("mid rst leds_dash", {24'd0, leds_d}, 32'hFF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post rst blank leds", {24'd0, leds_h}, 32'hFF);
        @(negedge clk);
        check("post rst leds", {24'd0, leds_h}, 32'hC0);
        check("post rst sel", {28'd0, sel_h}, 32'hE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed driver for an NDIGITS common-anode 7-segment display with shared segment lines.
- Time-multiplexes one digit at a time, with a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value behind a load/ack handshake.
- Adds hex mode, per-digit decimal points and leading-zero blanking.
- Sits between the lab datapath (counters, ADC readout) and the board display pins.

Parameters:
NDIGITS, 4, number of digits (1..8); digit 0 is least significant.
SCAN_DIV, 50000, clocks per digit slot, blank gap included (> BLANK_CYC).
BLANK_CYC, 500, clocks per slot with all digits off (>= 1).
HEX_MODE, 0, 1: codes 10-15 display A b C d E F; 0: they display a dash.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
digits_in  in  4*NDIGITS  BCD/hex nibbles; nibble i = digits_in[4i+3:4i]
dp_in  in  NDIGITS  decimal point request per digit, 1 = lit
load  in  1  one-cycle strobe; captures digits_in, dp_in, lzb_en
lzb_en  in  1  leading-zero blanking enable
load_ack  out  1  one-cycle pulse when a staged value becomes displayed
frame_done  out  1  one-cycle pulse at the end of each full scan frame
leds  out  8  active-low segments, bit7 = DP, bits6:0 = g..a
digit_sel_n  out  NDIGITS  active-low digit enables, at most one low

Behaviour:
- Reset (asynchronous, active-low; one clock clk):
  - leds=8'hFF, digit_sel_n all 1, load_ack=0, frame_done=0.
  - State BLANK, digit index 0, slot counter 0.
  - Display and staging registers cleared (value 0, DP off, lzb off); pending=0.
- Reset mid-scan: all outputs return to reset values immediately, with no waiting for the clock edge.
- FSM, Moore, all outputs registered:
  - BLANK: leds=FF, digit_sel_n all 1 for BLANK_CYC clocks, then SHOW.
  - SHOW: digit_sel_n[idx]=0, leds=encoded digit idx for SCAN_DIV-BLANK_CYC clocks, then BLANK with idx+1.
  - After the SHOW of idx=NDIGITS-1, idx wraps to 0 and frame_done pulses on the BLANK entry cycle.
- Encoding (active-low):
  - 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - 10-15, HEX_MODE=1: 88 83 C6 A1 86 8E.
  - 10-15, HEX_MODE=0: BF (dash, segment g only).
  - leds[7] = ~dp for the shown digit.
- Leading-zero blanking (display lzb=1):
  - A digit i>0 is blanked when it and every more significant digit are 0.
  - A blanked digit drives bits6:0 all 1; its DP is still honoured and its digit_sel_n slot still activates, so scan timing is unchanged.
  - Digit 0 is never blanked.
- Load handshake:
  - load=1: staging <= {digits_in, dp_in, lzb_en}, pending <= 1.
  - At the frame wrap, if pending: display <= staging, pending <= 0, load_ack pulses on the same cycle as frame_done.
  - Several loads in one frame: the last wins, and exactly one load_ack is produced.
  - load on the wrap cycle itself: the wrap transfers the previous staging, and the new value is pending for the next frame.
- The displayed value never changes mid-frame.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment constants SEG_0..SEG_F, SEG_DASH=8'hBF, SEG_OFF=8'hFF;
  - typedef enum {BLANK, SHOW} scan_state_t;
  - function seg7_code(nibble, hex_mode).
- One combinational sub-module, seg7_encode (nibble, hex_mode, blank, dp -> leds), used once for the current digit.
- The top level holds the FSM, counters, staging/display registers and LZB mask.

Test Plan:
Bench parameters: NDIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
1. Reset and first load.
   - Stimulus: reset_n low, then release and load 16'h1234 with dp 0, lzb 0.
   - Response: during reset, leds=FF and digit_sel_n=1111.
   - Response: load_ack coincides with frame_done; next frame shows digit0 4 -> 99 with sel=1110 for 6 clocks, then 2 clocks of FF/1111, then digit1 3 -> B0 with sel=1101.
2. Hex vs dash.
   - Stimulus: load 16'hABCD.
   - Response, HEX_MODE=1: digits 0..3 show A1 C6 83 88.
   - Response, HEX_MODE=0: all four show BF.
3. Leading-zero blanking, lzb=1.
   - 16'h0005: digits 3..1 show FF (sel still active), digit0 shows 92.
   - 16'h0000: digit0 shows C0.
   - 16'h0100: digit3 FF, digit2 F9, digit1 C0, digit0 C0.
   - dp_in=4'b0100 with 16'h0005: digit2 shows 7F.
4. Handshake.
   - Two loads (16'h1111 then 16'h2222) mid-frame: display unchanged until the wrap; a single load_ack; 2222 is displayed.
   - Load on the wrap cycle: takes effect one frame later, with a second load_ack.
5. Mid-scan reset: assert reset_n low during SHOW of digit 2 -> leds=FF and sel=1111 before the next clk edge; after release, digit0 shows C0 (cleared display).
